// File: rtl/counter_unit.sv
// counter_unit
// ---------------------------------------------------------------------------
// Free-running unsigned up-counter, WIDTH bits wide. It gives surrounding
// logic a simple cycle count and makes clock activity easy to see during
// waveform-based bring-up.
//
// There is no enable, load, direction control or overflow flag. While out of
// reset the counter steps by one on every rising clock edge. After all-ones
// it wraps to zero, so the sequence repeats every 2**WIDTH cycles.
//
// Ports (positional order count, clk, reset):
//   count : out, WIDTH bits. Registered count, taken straight from the
//           state register. There is no combinational path from any input.
//   clk   : in. System clock. All state changes happen on its rising edge.
//   reset : in. Asynchronous, active-low. 0 clears count at once and holds
//           it at 0 whatever clk does.
//
// Parameters:
//   WIDTH : counter width in bits, legal range 1..32, default 4.
//
// Reset release is expected to happen away from active clock edges. This
// block adds no synchroniser for it.
// ---------------------------------------------------------------------------
module counter_unit #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] count,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;

  // The add is WIDTH bits wide, so the carry out of the MSB is dropped.
  // That gives the wrap from all-ones back to zero.
  assign w_count_next = r_count + WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_counter_unit.sv
// tb_counter_unit
// ---------------------------------------------------------------------------
// Bench for counter_unit. It drives three instances side by side, with
// WIDTH = 4, 1 and 8. All three share one clock and one reset.
//
// The driver moves the clock by hand, so the clock can be held stopped while
// reset is exercised. After each event the driver pushes the expected values
// into per-instance queues and fires sample_ev. A separate monitor process
// pops the queues and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_counter_unit;

  // Clock and reset.
  logic clk;
  logic reset;

  logic [3:0] count4;
  logic [0:0] count1;
  logic [7:0] count8;

  counter_unit #(.WIDTH(4)) u_dut4 (.count(count4), .clk(clk), .reset(reset));
  counter_unit #(.WIDTH(1)) u_dut1 (.count(count1), .clk(clk), .reset(reset));
  counter_unit #(.WIDTH(8)) u_dut8 (.count(count8), .clk(clk), .reset(reset));

  // Scoreboard state.
  logic [3:0] exp4_q[$];
  logic [0:0] exp1_q[$];
  logic [7:0] exp8_q[$];
  string      tag_q[$];

  int tests_run  = 0;
  int tests_fail = 0;

  event sample_ev;

  // Reference counts. Each one wraps at its own width through the mask.
  int m4;
  int m1;
  int m8;

  // Monitor: one pop and compare per instance on every sample request.
  always begin
    string      tag;
    logic [3:0] e4;
    logic [0:0] e1;
    logic [7:0] e8;
    @(sample_ev);
    if (tag_q.size() == 0 || exp4_q.size() == 0 || exp1_q.size() == 0 ||
        exp8_q.size() == 0) begin
      tests_run++;
      tests_fail++;
      $display("FAIL scoreboard_empty: sample with no expected entry queued");
    end else begin
      tag = tag_q.pop_front();
      e4  = exp4_q.pop_front();
      e1  = exp1_q.pop_front();
      e8  = exp8_q.pop_front();
      tests_run++;
      if (count4 !== e4) begin
        tests_fail++;
        $display("FAIL %s w4: got %0d expected %0d", tag, count4, e4);
      end
      tests_run++;
      if (count1 !== e1) begin
        tests_fail++;
        $display("FAIL %s w1: got %0d expected %0d", tag, count1, e1);
      end
      tests_run++;
      if (count8 !== e8) begin
        tests_fail++;
        $display("FAIL %s w8: got %0d expected %0d", tag, count8, e8);
      end
    end
  end

  // Driver tasks.

  // Queue the current reference values and ask the monitor to sample.
  task automatic push_sample(input string tag);
    tag_q.push_back(tag);
    exp4_q.push_back(4'(m4));
    exp1_q.push_back(1'(m1));
    exp8_q.push_back(8'(m8));
    ->sample_ev;
    #1;
  endtask

  // Queue hand-computed values directly instead of the reference counts.
  task automatic push_directed(input string tag, input logic [3:0] e4,
                               input logic [0:0] e1, input logic [7:0] e8);
    tag_q.push_back(tag);
    exp4_q.push_back(e4);
    exp1_q.push_back(e1);
    exp8_q.push_back(e8);
    ->sample_ev;
    #1;
  endtask

  // One full clock period. The references step only if reset is high at the
  // rising edge. Sampling happens 1 ns after the edge.
  task automatic edge_and_check(input string tag);
    clk = 1'b1;
    if (reset) begin
      m4 = (m4 + 1) & 4'hF;
      m1 = (m1 + 1) & 1'h1;
      m8 = (m8 + 1) & 8'hFF;
    end
    #1;
    push_sample(tag);
    #3;
    clk = 1'b0;
    #5;
  endtask

  // Assert reset midway between edges (clk low) and check the clear at once.
  task automatic assert_reset(input string tag);
    reset = 1'b0;
    m4 = 0;
    m1 = 0;
    m8 = 0;
    #1;
    push_sample(tag);
  endtask

  task automatic release_reset();
    #2;
    reset = 1'b1;
    #2;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    m4 = 0;
    m1 = 0;
    m8 = 0;
    #3;

    // Reset with the clock stopped must clear the count immediately.
    assert_reset("reset_no_clk");
    #7;
    push_directed("reset_hold_no_clk", 4'd0, 1'b0, 8'd0);

    // A one-clock reset pulse, then release away from the edge.
    edge_and_check("reset_pulse_edge");
    release_reset();

    // The first five edges after release give 1..5 at WIDTH 4.
    for (int i = 0; i < 5; i++) edge_and_check("count_after_release");
    push_directed("five_edges", 4'd5, 1'b1, 8'd5);

    // Run to edge 15, where WIDTH 4 reads 15. Edge 16 wraps to 0, edge 17
    // gives 1.
    for (int i = 5; i < 15; i++) edge_and_check("count_to_15");
    push_directed("w4_at_15", 4'd15, 1'b1, 8'd15);
    edge_and_check("wrap_edge16");
    push_directed("w4_wrap_zero", 4'd0, 1'b0, 8'd16);
    edge_and_check("after_wrap");
    push_directed("w4_after_wrap", 4'd1, 1'b1, 8'd17);

    // Reset mid-count, taken when WIDTH 4 reads 9.
    for (int i = 0; i < 8; i++) edge_and_check("count_to_9");
    push_directed("w4_at_9", 4'd9, 1'b1, 8'd25);
    assert_reset("mid_count_reset");
    #3;
    for (int i = 0; i < 3; i++) edge_and_check("held_in_reset");
    release_reset();
    edge_and_check("resume_from_0");
    push_directed("resume_value", 4'd1, 1'b1, 8'd1);

    // WIDTH 8: 256 edges from reset give 0, and 300 edges give 44.
    // WIDTH 1 keeps toggling throughout.
    assert_reset("w8_run_reset");
    #3;
    release_reset();
    for (int i = 0; i < 256; i++) edge_and_check("w8_run");
    push_directed("w8_after_256", 4'd0, 1'b0, 8'd0);
    for (int i = 256; i < 300; i++) edge_and_check("w8_run");
    push_directed("w8_after_300", 4'd12, 1'b0, 8'd44);

    #5;
    tests_run++;
    if (exp4_q.size() != 0 || tag_q.size() != 0) begin
      tests_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0",
               tag_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

  // Watchdog, so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
